// File: rtl/keypad_event_scanner_if.sv
// Key event handshake between the keypad scanner (master) and its consumer (slave).
interface keypad_event_scanner_if #(
    parameter int KEY_BITS = 4
);
    logic [KEY_BITS-1:0] keyCode;
    logic                keyValid;
    logic                keyRepeat;
    logic                keyAck;

    modport master (
        output keyCode,
        output keyValid,
        output keyRepeat,
        input  keyAck
    );

    modport slave (
        input  keyCode,
        input  keyValid,
        input  keyRepeat,
        output keyAck
    );
endinterface

// File: rtl/keypad_event_scanner.sv
// Matrix keypad scanner: one-hot column drive, per-frame row sampling, frame-level
// debounce, press / auto-repeat events delivered over a valid/ack handshake.
module keypad_event_scanner #(
    parameter int ROWS            = 4,
    parameter int COLS            = 3,
    parameter int KEY_BITS        = 4,
    parameter int SCAN_DIV        = 1000,
    parameter int DEBOUNCE_FRAMES = 8,
    parameter int REPEAT_EN       = 0,
    parameter int REPEAT_DELAY    = 50,
    parameter int REPEAT_RATE     = 10
) (
    input  logic                    scanClock,
    input  logic                    reset,
    input  logic [ROWS-1:0]         keypadRows,
    output logic [COLS-1:0]         keypadColumns,
    output logic                    keyHeld,
    output logic                    overflow,
    keypad_event_scanner_if.master  evt
);
    localparam int SLOT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int COL_W  = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int DB_W   = $clog2(DEBOUNCE_FRAMES + 1);
    localparam int REP_W  = $clog2(REPEAT_DELAY + REPEAT_RATE + 1);

    localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(SCAN_DIV - 1);
    localparam logic [COL_W-1:0]  COL_LAST  = COL_W'(COLS - 1);
    localparam logic [DB_W-1:0]   DB_MAX    = DB_W'(DEBOUNCE_FRAMES);
    localparam logic [REP_W-1:0]  REP_FIRST = REP_W'(REPEAT_DELAY);
    localparam logic [REP_W-1:0]  REP_NEXT  = REP_W'(REPEAT_DELAY + REPEAT_RATE);

    // Scan state and per-frame intersection accumulator (hit count saturates at 2 = MULTI)
    logic [SLOT_W-1:0]   r_slot_cnt;
    logic [COL_W-1:0]    r_col_idx;
    logic [COLS-1:0]     r_cols;
    logic [1:0]          r_hit_cnt;
    logic [KEY_BITS-1:0] r_hit_code;

    // Debounce / repeat state; a frame result is {is_key, code}, code forced to 0 for NONE
    logic                r_prev_key;
    logic [KEY_BITS-1:0] r_prev_code;
    logic [DB_W-1:0]     r_match_cnt;
    logic                r_stable_key;
    logic [KEY_BITS-1:0] r_stable_code;
    logic [REP_W-1:0]    r_rep_cnt;

    // Event output registers
    logic [KEY_BITS-1:0] r_key_code;
    logic                r_key_valid;
    logic                r_key_repeat;
    logic                r_overflow;

    logic                w_slot_end;
    logic                w_frame_end;
    logic [COL_W-1:0]    w_col_next;
    logic [1:0]          w_row_hits;
    logic [KEY_BITS-1:0] w_row_base;
    logic [KEY_BITS-1:0] w_slot_code;
    logic [2:0]          w_sum;
    logic [1:0]          w_tot_hits;
    logic [KEY_BITS-1:0] w_tot_code;
    logic                w_res_key;
    logic [KEY_BITS-1:0] w_res_code;
    logic                w_match;
    logic [DB_W-1:0]     w_cnt_next;
    logic                w_accept;
    logic [REP_W-1:0]    w_rep_inc;
    logic                w_evt;
    logic                w_evt_rep;
    logic [KEY_BITS-1:0] w_evt_code;

    assign w_slot_end  = (r_slot_cnt == SLOT_LAST);
    assign w_frame_end = w_slot_end && (r_col_idx == COL_LAST);
    assign w_col_next  = (r_col_idx == COL_LAST) ? '0 : r_col_idx + 1'b1;

    // Count active rows in the driven column and form the code of the last one seen
    always_comb begin
        w_row_hits = 2'd0;
        w_row_base = '0;
        for (int r = 0; r < ROWS; r++) begin
            if (keypadRows[r]) begin
                if (w_row_hits != 2'd2) w_row_hits = w_row_hits + 2'd1;
                w_row_base = KEY_BITS'(r * COLS);
            end
        end
        w_slot_code = w_row_base + KEY_BITS'(r_col_idx);
        w_sum       = {1'b0, r_hit_cnt} + {1'b0, w_row_hits};
        w_tot_hits  = (w_sum > 3'd1) ? 2'd2 : w_sum[1:0];
        w_tot_code  = (w_row_hits != 2'd0) ? w_slot_code : r_hit_code;
        w_res_key   = (w_tot_hits == 2'd1);
        w_res_code  = w_res_key ? w_tot_code : '0;
    end

    // Debounce decision and event generation, evaluated on the frame-end cycle
    always_comb begin
        w_match    = (w_res_key == r_prev_key) && (w_res_code == r_prev_code);
        if (!w_match)                w_cnt_next = DB_W'(1);
        else if (r_match_cnt == DB_MAX) w_cnt_next = r_match_cnt;
        else                         w_cnt_next = r_match_cnt + 1'b1;
        w_accept   = (w_cnt_next == DB_MAX) &&
                     ((w_res_key != r_stable_key) || (w_res_code != r_stable_code));
        w_rep_inc  = r_rep_cnt + 1'b1;
        w_evt_rep  = w_frame_end && !w_accept && r_stable_key && (REPEAT_EN != 0) &&
                     ((w_rep_inc == REP_FIRST) || (w_rep_inc == REP_NEXT));
        w_evt      = (w_frame_end && w_accept && w_res_key) || w_evt_rep;
        w_evt_code = w_evt_rep ? r_stable_code : w_res_code;
    end

    // Column drive, slot timing and frame accumulation
    always_ff @(posedge scanClock) begin
        if (reset) begin
            r_slot_cnt <= '0;
            r_col_idx  <= '0;
            r_cols     <= COLS'(1);
            r_hit_cnt  <= 2'd0;
            r_hit_code <= '0;
        end else if (w_slot_end) begin
            r_slot_cnt <= '0;
            r_col_idx  <= w_col_next;
            r_cols     <= COLS'(1) << w_col_next;
            r_hit_cnt  <= w_frame_end ? 2'd0 : w_tot_hits;
            r_hit_code <= w_frame_end ? '0 : w_tot_code;
        end else begin
            r_slot_cnt <= r_slot_cnt + 1'b1;
        end
    end

    // Frame-end update of debounce history, stable state and repeat frame counter
    always_ff @(posedge scanClock) begin
        if (reset) begin
            r_prev_key    <= 1'b0;
            r_prev_code   <= '0;
            r_match_cnt   <= '0;
            r_stable_key  <= 1'b0;
            r_stable_code <= '0;
            r_rep_cnt     <= '0;
        end else if (w_frame_end) begin
            r_prev_key  <= w_res_key;
            r_prev_code <= w_res_code;
            r_match_cnt <= w_cnt_next;
            if (w_accept) begin
                r_stable_key  <= w_res_key;
                r_stable_code <= w_res_code;
                r_rep_cnt     <= '0;
            end else if (r_stable_key && (REPEAT_EN != 0)) begin
                r_rep_cnt <= (w_rep_inc == REP_NEXT) ? REP_FIRST : w_rep_inc;
            end
        end
    end

    // Handshake: load on free slot or same-cycle ack, otherwise drop and flag overflow
    always_ff @(posedge scanClock) begin
        if (reset) begin
            r_key_code   <= '0;
            r_key_valid  <= 1'b0;
            r_key_repeat <= 1'b0;
            r_overflow   <= 1'b0;
        end else if (!r_key_valid || evt.keyAck) begin
            r_key_valid <= w_evt;
            if (w_evt) begin
                r_key_code   <= w_evt_code;
                r_key_repeat <= w_evt_rep;
            end
        end else if (w_evt) begin
            r_overflow <= 1'b1;
        end
    end

    assign keypadColumns = r_cols;
    assign keyHeld       = r_stable_key;
    assign overflow      = r_overflow;
    assign evt.keyCode   = r_key_code;
    assign evt.keyValid  = r_key_valid;
    assign evt.keyRepeat = r_key_repeat;
endmodule

// File: tb/tb_keypad_event_scanner.sv
// Directed bench: two scanners (repeat off / repeat on) driven by a shared keypad model.
module tb_keypad_event_scanner;
    logic             clk;
    logic             reset;
    logic             ack;
    logic [3:0][2:0]  key_m;
    logic [3:0]       rows0, rows1;
    logic [2:0]       cols0, cols1;
    logic             held0, held1, ovf0, ovf1;
    int               checks = 0;
    int               failures = 0;
    int               evt0 = 0;
    int               evt1 = 0;
    int               base;

    keypad_event_scanner_if #(.KEY_BITS(4)) if0 ();
    keypad_event_scanner_if #(.KEY_BITS(4)) if1 ();
    assign if0.keyAck = ack;
    assign if1.keyAck = ack;

    keypad_event_scanner #(
        .ROWS(4), .COLS(3), .KEY_BITS(4), .SCAN_DIV(4), .DEBOUNCE_FRAMES(3),
        .REPEAT_EN(0), .REPEAT_DELAY(4), .REPEAT_RATE(2)
    ) dut0 (
        .scanClock(clk), .reset(reset), .keypadRows(rows0), .keypadColumns(cols0),
        .keyHeld(held0), .overflow(ovf0), .evt(if0)
    );

    keypad_event_scanner #(
        .ROWS(4), .COLS(3), .KEY_BITS(4), .SCAN_DIV(4), .DEBOUNCE_FRAMES(3),
        .REPEAT_EN(1), .REPEAT_DELAY(4), .REPEAT_RATE(2)
    ) dut1 (
        .scanClock(clk), .reset(reset), .keypadRows(rows1), .keypadColumns(cols1),
        .keyHeld(held1), .overflow(ovf1), .evt(if1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Keypad matrix: a pressed key connects its column drive to its row
    always_comb begin
        for (int r = 0; r < 4; r++) begin
            rows0[r] = |(key_m[r] & cols0);
            rows1[r] = |(key_m[r] & cols1);
        end
    end

    // Accepted-event counters
    always @(posedge clk) begin
        if (if0.keyValid && if0.keyAck) evt0 <= evt0 + 1;
        if (if1.keyValid && if1.keyAck) evt1 <= evt1 + 1;
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        reset = 1'b1;
        ack   = 1'b0;
        key_m = '0;
        tick(3);
        reset = 1'b0;

        // 1: idle scanning after reset
        check("rst_cols", 32'(cols0), 32'h1);
        check("rst_valid", 32'(if0.keyValid), 32'h0);
        check("rst_held", 32'(held0), 32'h0);
        check("rst_code", 32'(if0.keyCode), 32'h0);
        check("rst_ovf", 32'(ovf0), 32'h0);
        tick(4);
        check("cols_c1", 32'(cols0), 32'h2);
        tick(4);
        check("cols_c2", 32'(cols0), 32'h4);
        tick(4);
        check("cols_wrap", 32'(cols0), 32'h1);
        check("cols_wrap_d1", 32'(cols1), 32'h1);
        check("idle_valid", 32'(if0.keyValid), 32'h0);

        // 2: clean press of key 7 (row2/col1), ack tied high
        ack = 1'b1;
        base = evt0;
        key_m[2][1] = 1'b1;
        tick(35);
        check("k7_early_valid", 32'(if0.keyValid), 32'h0);
        check("k7_early_held", 32'(held0), 32'h0);
        tick(1);
        check("k7_valid", 32'(if0.keyValid), 32'h1);
        check("k7_code", 32'(if0.keyCode), 32'h7);
        check("k7_rep", 32'(if0.keyRepeat), 32'h0);
        check("k7_held", 32'(held0), 32'h1);
        tick(1);
        check("k7_acked", 32'(if0.keyValid), 32'h0);
        tick(23);
        check("k7_still_held", 32'(held0), 32'h1);
        check("k7_one_evt", 32'(evt0 - base), 32'h1);
        key_m = '0;
        tick(35);
        check("k7_rel_early", 32'(held0), 32'h1);
        tick(1);
        check("k7_released", 32'(held0), 32'h0);
        check("k7_rel_valid", 32'(if0.keyValid), 32'h0);
        check("k7_rel_noevt", 32'(evt0 - base), 32'h1);

        // 3: key present only on alternating frames
        base = evt0;
        for (int i = 0; i < 6; i++) begin
            key_m[2][1] = ((i % 2) == 0);
            tick(12);
        end
        key_m = '0;
        check("bounce_held", 32'(held0), 32'h0);
        check("bounce_noevt", 32'(evt0 - base), 32'h0);
        tick(12);

        // 4: two keys -> NONE; release one -> remaining key 0
        base = evt0;
        key_m[0][0] = 1'b1;
        key_m[1][2] = 1'b1;
        tick(48);
        check("multi_held", 32'(held0), 32'h0);
        check("multi_noevt", 32'(evt0 - base), 32'h0);
        key_m[1][2] = 1'b0;
        tick(35);
        check("k0_early_valid", 32'(if0.keyValid), 32'h0);
        tick(1);
        check("k0_valid", 32'(if0.keyValid), 32'h1);
        check("k0_code", 32'(if0.keyCode), 32'h0);
        check("k0_held", 32'(held0), 32'h1);
        key_m = '0;
        tick(36);
        check("k0_released", 32'(held0), 32'h0);

        // 5: no ack; key 4 pending, key 9 dropped -> overflow
        ack = 1'b0;
        key_m[1][1] = 1'b1;
        tick(36);
        check("k4_valid", 32'(if0.keyValid), 32'h1);
        check("k4_code", 32'(if0.keyCode), 32'h4);
        key_m = '0;
        tick(36);
        check("k4_rel_held", 32'(held0), 32'h0);
        check("k4_rel_valid", 32'(if0.keyValid), 32'h1);
        key_m[3][0] = 1'b1;
        tick(35);
        check("ovf_early", 32'(ovf0), 32'h0);
        tick(1);
        check("ovf_set", 32'(ovf0), 32'h1);
        check("ovf_valid", 32'(if0.keyValid), 32'h1);
        check("ovf_code", 32'(if0.keyCode), 32'h4);
        check("k9_held", 32'(held0), 32'h1);
        ack = 1'b1;
        tick(1);
        check("ovf_ack_valid", 32'(if0.keyValid), 32'h0);
        ack = 1'b0;
        tick(5);
        check("ovf_sticky", 32'(ovf0), 32'h1);

        // 6: reset, then auto-repeat on key 3 (row1/col0)
        key_m = '0;
        reset = 1'b1;
        tick(2);
        check("rst2_ovf", 32'(ovf0), 32'h0);
        check("rst2_held", 32'(held0), 32'h0);
        check("rst2_cols", 32'(cols1), 32'h1);
        reset = 1'b0;
        ack = 1'b1;
        base = evt1;
        key_m[1][0] = 1'b1;
        tick(36);
        check("k3_press_valid", 32'(if1.keyValid), 32'h1);
        check("k3_press_rep", 32'(if1.keyRepeat), 32'h0);
        check("k3_press_code", 32'(if1.keyCode), 32'h3);
        check("k3_held", 32'(held1), 32'h1);
        tick(47);
        check("rep1_early", 32'(if1.keyValid), 32'h0);
        tick(1);
        check("rep1_valid", 32'(if1.keyValid), 32'h1);
        check("rep1_flag", 32'(if1.keyRepeat), 32'h1);
        check("rep1_code", 32'(if1.keyCode), 32'h3);
        tick(24);
        check("rep2_valid", 32'(if1.keyValid), 32'h1);
        check("rep2_flag", 32'(if1.keyRepeat), 32'h1);
        tick(24);
        check("rep3_valid", 32'(if1.keyValid), 32'h1);
        check("rep3_flag", 32'(if1.keyRepeat), 32'h1);
        tick(6);
        check("rep_evt_count", 32'(evt1 - base), 32'h4);
        check("midhold_held", 32'(held1), 32'h1);
        check("midhold_cols", 32'(cols1), 32'h2);
        reset = 1'b1;
        tick(1);
        check("rst3_valid", 32'(if1.keyValid), 32'h0);
        check("rst3_rep", 32'(if1.keyRepeat), 32'h0);
        check("rst3_code", 32'(if1.keyCode), 32'h0);
        check("rst3_held", 32'(held1), 32'h0);
        check("rst3_ovf", 32'(ovf1), 32'h0);
        check("rst3_cols", 32'(cols1), 32'h1);
        reset = 1'b0;
        key_m = '0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
